nf1_cml_reg_master: RTL and testbench



---
 rtl/nf1_cml_reg_master.sv | 176 +++++++++++++++++
 tb/tb_nf1_cml_reg_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf1_cml_reg_master.sv
// Single-outstanding AXI4-Lite register master: turns one cmd into one AW/W/B or AR/R
// transaction inside the C_BASEADDR window and returns a response with saturating statistics.
module nf1_cml_reg_master #(
  parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASEADDR         = 32'h77e60000,
  parameter int unsigned                   C_CNT_WIDTH        = 16
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,

  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [15:0]                   cmd_offset,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata,

  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                    rsp_resp,

  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,

  output logic [C_CNT_WIDTH-1:0]        wr_count,
  output logic [C_CNT_WIDTH-1:0]        rd_count,
  output logic [C_CNT_WIDTH-1:0]        err_count
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  state_t                          state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic                            write_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr;
  logic                            aw_done;
  logic                            w_done;

  // Word-aligned target address; masking keeps the low offset bits out of the address.
  assign cmd_addr = C_BASEADDR | C_M_AXI_ADDR_WIDTH'(cmd_offset & 16'hFFFC);

  // A channel counts as done once its valid has already dropped or it handshakes this cycle.
  assign aw_done = !m_axi_awvalid || m_axi_awready;
  assign w_done  = !m_axi_wvalid  || m_axi_wready;

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;

  function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + C_CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      wr_count      <= '0;
      rd_count      <= '0;
      err_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            write_q   <= cmd_write;
            if (cmd_write) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR_REQ;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RD_REQ;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        WR_REQ: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= write_q;
            rsp_rdata    <= '0;
            rsp_resp     <= m_axi_bresp;
            wr_count     <= sat_inc(wr_count);
            if (m_axi_bresp != 2'b00) err_count <= sat_inc(err_count);
            state        <= DONE;
          end
        end

        RD_REQ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= write_q;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rd_count     <= sat_inc(rd_count);
            if (m_axi_rresp != 2'b00) err_count <= sat_inc(err_count);
            state        <= DONE;
          end
        end

        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nf1_cml_reg_master.sv
// Randomized bench for nf1_cml_reg_master: a delay-configurable AXI4-Lite slave plus a
// transaction-level reference model (address, latency, response and saturating counters).
module tb_nf1_cml_reg_master;

  localparam logic [31:0] BASE = 32'h77e60000;
  localparam int          CMAX = 15;

  logic        clk;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_offset;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [3:0]  wr_count, rd_count, err_count;

  int n_checks = 0;
  int n_errors = 0;

  nf1_cml_reg_master #(.C_CNT_WIDTH(4)) dut (
    .axi_aclk(clk), .axi_aresetn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_offset(cmd_offset), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave knobs: cycles of valid before ready, and cycles from request to response.
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, resp_dly = 0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
  logic [31:0] s_rdata = '0;

  int   aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
  logic aw_got, w_got, ar_got;
  logic aw_now, w_now, ar_now;

  assign m_axi_awready = (aw_cnt >= aw_dly);
  assign m_axi_wready  = (w_cnt >= w_dly);
  assign m_axi_arready = (ar_cnt >= ar_dly);
  assign aw_now = m_axi_awvalid && m_axi_awready;
  assign w_now  = m_axi_wvalid && m_axi_wready;
  assign ar_now = m_axi_arvalid && m_axi_arready;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_wait <= 0; r_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
      m_axi_rvalid <= 1'b0; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
    end else begin
      if (aw_now) aw_cnt <= 0; else if (m_axi_awvalid) aw_cnt <= aw_cnt + 1;
      if (w_now)  w_cnt  <= 0; else if (m_axi_wvalid)  w_cnt  <= w_cnt + 1;
      if (ar_now) ar_cnt <= 0; else if (m_axi_arvalid) ar_cnt <= ar_cnt + 1;

      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if ((aw_got || aw_now) && (w_got || w_now)) begin
        if (b_wait >= resp_dly) begin
          m_axi_bvalid <= 1'b1; m_axi_bresp <= s_bresp;
          aw_got <= 1'b0; w_got <= 1'b0; b_wait <= 0;
        end else begin
          aw_got <= 1'b1; w_got <= 1'b1; b_wait <= b_wait + 1;
        end
      end else begin
        if (aw_now) aw_got <= 1'b1;
        if (w_now)  w_got  <= 1'b1;
      end

      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      if (ar_got || ar_now) begin
        if (r_wait >= resp_dly) begin
          m_axi_rvalid <= 1'b1; m_axi_rresp <= s_rresp; m_axi_rdata <= s_rdata;
          ar_got <= 1'b0; r_wait <= 0;
        end else begin
          ar_got <= 1'b1; r_wait <= r_wait + 1;
        end
      end
    end
  end

  // Channel monitor: handshake totals, valid run lengths and address/data stability.
  int          aw_run = 0, w_run = 0, ar_run = 0;
  int          aw_len = 0, w_len = 0, ar_len = 0;
  int          aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0, moves = 0;
  logic [31:0] aw_first, w_first, ar_first, aw_last, w_last, ar_last;

  always @(negedge clk) begin
    if (m_axi_awvalid) begin
      if (aw_run == 0) aw_first = m_axi_awaddr; else if (m_axi_awaddr != aw_first) moves++;
      aw_run++;
      if (m_axi_awready) begin aw_len = aw_run; aw_last = m_axi_awaddr; aw_hs++; aw_run = 0; end
    end else aw_run = 0;
    if (m_axi_wvalid) begin
      if (w_run == 0) w_first = m_axi_wdata; else if (m_axi_wdata != w_first) moves++;
      w_run++;
      if (m_axi_wready) begin w_len = w_run; w_last = m_axi_wdata; w_hs++; w_run = 0; end
    end else w_run = 0;
    if (m_axi_arvalid) begin
      if (ar_run == 0) ar_first = m_axi_araddr; else if (m_axi_araddr != ar_first) moves++;
      ar_run++;
      if (m_axi_arready) begin ar_len = ar_run; ar_last = m_axi_araddr; ar_hs++; ar_run = 0; end
    end else ar_run = 0;
    if (m_axi_bvalid && m_axi_bready) b_hs++;
    if (m_axi_rvalid && m_axi_rready) r_hs++;
  end

  // Reference model state: completed transactions since the last reset.
  int exp_wr = 0, exp_rd = 0, exp_err = 0;

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic do_txn(input bit wr, input logic [15:0] off, input logic [31:0] wd,
                        input int a_d, input int w_d, input int rs_d, input logic [1:0] resp,
                        input logic [31:0] rdat, input int stall);
    int lat, guard, exp_lat;
    int aw0, w0, ar0, b0, r0, mv0;
    logic [31:0] exp_addr, exp_rdata;
    aw_dly = a_d; ar_dly = a_d; w_dly = w_d; resp_dly = rs_d;
    s_bresp = resp; s_rresp = resp; s_rdata = rdat;
    exp_addr  = BASE + 32'(off - (off % 16'd4));
    exp_rdata = wr ? 32'h0 : rdat;
    exp_lat   = 3 + rs_d + (wr ? ((a_d > w_d) ? a_d : w_d) : a_d);
    aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs; b0 = b_hs; r0 = r_hs; mv0 = moves;

    cmd_valid = 1'b1; cmd_write = wr; cmd_offset = off; cmd_wdata = wd;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    check("cmd_ready_idle", cmd_ready, 1);
    check("b_r_ready_idle", {m_axi_bready, m_axi_rready}, 0);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_offset = 16'($urandom); cmd_wdata = $urandom;
    check("cmd_ready_busy", cmd_ready, 0);

    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    check("latency", lat, exp_lat);

    if (wr) exp_wr++; else exp_rd++;
    if (resp != 2'b00) exp_err++;
    if (wr) begin
      check("aw_hs", aw_hs - aw0, 1);
      check("w_hs", w_hs - w0, 1);
      check("b_hs", b_hs - b0, 1);
      check("aw_cycles", aw_len, a_d + 1);
      check("w_cycles", w_len, w_d + 1);
      check("awaddr", aw_last, exp_addr);
      check("wdata", w_last, wd);
    end else begin
      check("ar_hs", ar_hs - ar0, 1);
      check("r_hs", r_hs - r0, 1);
      check("ar_cycles", ar_len, a_d + 1);
      check("araddr", ar_last, exp_addr);
    end
    check("addr_data_stable", moves - mv0, 0);

    for (int i = 0; i <= stall; i++) begin
      if (i > 0) @(negedge clk);
      check("rsp_valid", rsp_valid, 1);
      check("rsp_write", rsp_write, wr);
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("rsp_resp", rsp_resp, resp);
      check("cmd_ready_done", cmd_ready, 0);
    end
    check("wr_count", wr_count, sat(exp_wr));
    check("rd_count", rd_count, sat(exp_rd));
    check("err_count", err_count, sat(exp_err));

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after", rsp_valid, 0);
    check("cmd_ready_after", cmd_ready, 1);
  endtask

  initial begin
    int guard;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_offset = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}, 0);
    check("rst_readies", {m_axi_bready, m_axi_rready}, 0);
    check("rst_rsp", {rsp_write, rsp_resp, rsp_rdata}, 0);
    check("rst_counts", {wr_count, rd_count, err_count}, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("cmd_ready_post_rst", cmd_ready, 1);

    do_txn(1'b1, 16'h0013, 32'hA5A5_0001, 0, 0, 0, 2'b00, 32'h0, 0);
    check("awaddr_literal", aw_last, 32'h77e6_0010);
    do_txn(1'b1, 16'h0100, 32'h1234_5678, 3, 0, 0, 2'b00, 32'h0, 0);
    do_txn(1'b0, 16'h0004, 32'h0, 0, 0, 0, 2'b10, 32'hDEAD_BEEF, 0);
    do_txn(1'b1, 16'h0022, 32'hCAFE_F00D, 1, 2, 1, 2'b00, 32'h0, 5);

    // Abort a read while it waits in RD_RESP.
    ar_dly = 0; resp_dly = 20;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_offset = 16'h0008;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rready_in_rd_resp", m_axi_rready, 1);
    #2 rstn = 1'b0;
    #1;
    check("abort_arvalid", m_axi_arvalid, 0);
    check("abort_rready", m_axi_rready, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_cmd_ready", cmd_ready, 0);
    check("abort_counts", {wr_count, rd_count, err_count}, 0);
    exp_wr = 0; exp_rd = 0; exp_err = 0; resp_dly = 0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1 check("cmd_ready_release", cmd_ready, 0);
    @(negedge clk);
    check("cmd_ready_first_clk", cmd_ready, 1);

    // Drive the 4-bit write counter past saturation.
    for (int i = 0; i < 20; i++)
      do_txn(1'b1, 16'($urandom), $urandom, 0, 0, 0, 2'b00, 32'h0, 0);
    check("wr_count_sat", wr_count, 4'hF);

    for (int i = 0; i < 40; i++) begin
      bit          wr;
      logic [1:0]  resp;
      wr   = 1'($urandom_range(0, 1));
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_txn(wr, 16'($urandom), $urandom, int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), resp, $urandom,
             int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
